// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle rxvalid / framing_err pulses and a held copy of the last good byte.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line idle, waiting for rx_s to fall
// START     | counting to mid start bit; high there means a glitch
// DATA      | sampling 8 data bits LSB-first, one per CLKS_PER_BIT cycles
// STOP      | sampling the stop bit; high -> rxvalid, low -> framing_err
// WAIT_IDLE | break / bad frame, hold off until the line returns high
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    output logic       framing_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        rx_m;
    logic        rx_s;

    // Reset to 1 so a line held low through reset looks like a fresh falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rxbyte      <= '0;
            rxvalid     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            rxvalid     <= 1'b0;
            framing_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_M1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt <= '0;
                        if (rx_s) begin
                            rxbyte  <= shreg;
                            rxvalid <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule
